// File: rtl/fir_out_scaler_if.sv
// AXI-Stream beat bundle (valid/data/last/ready) shared by the FIR output
// scaler's input and output sides; width is set per instance.
interface fir_out_scaler_if #(
    parameter int pWIDTH = 32
);
    logic              tvalid;
    logic [pWIDTH-1:0] tdata;
    logic              tlast;
    logic              tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fir_out_scaler.sv
// Scales the FIR output stream (round-half-up shift, 16-bit saturation), buffers
// it in a small FIFO, checks frame length and counts saturated beats.
module fir_out_scaler #(
    parameter int pDATA_WIDTH = 32,
    parameter int pOUT_WIDTH  = 16,
    parameter int pFIFO_DEPTH = 4
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic [4:0]       cfg_shift,
    input  logic [31:0]      cfg_length,
    input  logic             sts_clr,
    fir_out_scaler_if.slave  s_axis,
    fir_out_scaler_if.master m_axis,
    output logic [15:0]      sat_count,
    output logic             len_err,
    output logic             frame_done
);

    localparam int PTR_W   = $clog2(pFIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int EXT_W   = pDATA_WIDTH + 1;
    localparam int ENTRY_W = pOUT_WIDTH + 1;

    // ------------------------------------------------------------------
    // Scaling datapath
    // ------------------------------------------------------------------
    logic signed [EXT_W-1:0] ext_data;
    logic signed [EXT_W-1:0] round_bias;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;
    logic signed [EXT_W-1:0] sat_max;
    logic signed [EXT_W-1:0] sat_min;
    logic [pOUT_WIDTH-1:0]   scaled;
    logic                    is_sat;

    always_comb begin
        ext_data   = {s_axis.tdata[pDATA_WIDTH-1], s_axis.tdata};
        round_bias = '0;
        if (cfg_shift != 5'd0) begin
            round_bias = {{(EXT_W-1){1'b0}}, 1'b1} << (cfg_shift - 5'd1);
        end
        // 33 bits hold the largest positive input plus the largest bias
        biased  = ext_data + round_bias;
        shifted = biased >>> cfg_shift;
        sat_max = {{(EXT_W-pOUT_WIDTH+1){1'b0}}, {(pOUT_WIDTH-1){1'b1}}};
        sat_min = {{(EXT_W-pOUT_WIDTH+1){1'b1}}, {(pOUT_WIDTH-1){1'b0}}};
        is_sat  = 1'b0;
        scaled  = shifted[pOUT_WIDTH-1:0];
        if (shifted > sat_max) begin
            is_sat = 1'b1;
            scaled = {1'b0, {(pOUT_WIDTH-1){1'b1}}};
        end else if (shifted < sat_min) begin
            is_sat = 1'b1;
            scaled = {1'b1, {(pOUT_WIDTH-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [pFIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               ready_reg;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign push = s_axis.tvalid & ready_reg;
    assign pop  = (count_reg != '0) & m_axis.tready;
    assign head = fifo_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < pFIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge axis_clk or negedge axis_rst_n) begin
                if (!axis_rst_n) begin
                    fifo_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_mem[gi] <= {s_axis.tlast, scaled};
                end
            end
        end
    endgenerate

    // Ready is registered from the next count so it never depends on m_tready
    // combinationally and stays low through reset.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            ready_reg <= (count_next < CNT_W'(pFIFO_DEPTH));
        end
    end

    assign s_axis.tready = ready_reg;
    assign m_axis.tvalid = (count_reg != '0);
    assign m_axis.tdata  = head[pOUT_WIDTH-1:0];
    assign m_axis.tlast  = head[pOUT_WIDTH];

    // ------------------------------------------------------------------
    // Frame length check and status
    // ------------------------------------------------------------------
    logic [31:0] beat_idx_reg;
    logic [31:0] last_idx;
    logic        len_mismatch;
    logic        sat_event;
    logic [15:0] sat_count_reg;
    logic        len_err_reg;
    logic        frame_done_reg;

    always_comb begin
        last_idx     = cfg_length - 32'd1;
        len_mismatch = 1'b0;
        if (push && (cfg_length != 32'd0)) begin
            if (s_axis.tlast) begin
                len_mismatch = (beat_idx_reg != last_idx);
            end else begin
                len_mismatch = (beat_idx_reg == last_idx);
            end
        end
        sat_event = push & is_sat;
    end

    // A clear coinciding with a new event leaves that event recorded.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            beat_idx_reg   <= '0;
            sat_count_reg  <= '0;
            len_err_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push) begin
                beat_idx_reg <= s_axis.tlast ? 32'd0 : beat_idx_reg + 32'd1;
            end
            if (sts_clr) begin
                sat_count_reg <= sat_event ? 16'd1 : 16'd0;
            end else if (sat_event && (sat_count_reg != 16'hFFFF)) begin
                sat_count_reg <= sat_count_reg + 16'd1;
            end
            len_err_reg    <= sts_clr ? len_mismatch : (len_err_reg | len_mismatch);
            frame_done_reg <= pop & head[pOUT_WIDTH];
        end
    end

    assign sat_count  = sat_count_reg;
    assign len_err    = len_err_reg;
    assign frame_done = frame_done_reg;

endmodule
